sq_fetch_sched: RTL and testbench

SQ_FETCH_SCHED -- requirements
Module: sq_fetch_sched

---
 rtl/sq_fetch_sched.sv | 123 ++++++++++++
 tb/tb_sq_fetch_sched.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sq_fetch_sched.sv
// Send-queue fetch scheduler: walks the SQ ring and issues one DataMover MM2S command per WQE.
// Optional completion watchdog enabled by defining SQ_TIMEOUT_EN.
module sq_fetch_sched #(
    parameter int unsigned WQE_BYTES      = 64,
    parameter int unsigned SQ_IDX_W       = 4,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                global_enable,
    input  logic [31:0]         sq_base_addr,
    input  logic [SQ_IDX_W:0]   sq_size,
    input  logic [SQ_IDX_W-1:0] sq_tail,
    output logic [SQ_IDX_W-1:0] hw_sq_head,
    output logic [71:0]         m_axis_mm2s_cmd_tdata,
    output logic                m_axis_mm2s_cmd_tvalid,
    input  logic                m_axis_mm2s_cmd_tready,
    input  logic                mm2s_rd_xfer_cmplt,
    output logic                busy,
    output logic [31:0]         wqe_processed,
    output logic                err_timeout,
    output logic [31:0]         debug_status_word
);

    localparam logic [1:0] IDLE       = 2'd0;
    localparam logic [1:0] ISSUE      = 2'd1;
    localparam logic [1:0] WAIT_CMPLT = 2'd2;
    localparam logic [1:0] ADVANCE    = 2'd3;

    logic [1:0]          state;
    logic [SQ_IDX_W-1:0] head;
    logic [71:0]         cmd;
    logic [31:0]         wqe_cnt;
    logic [7:0]          spurious;
    logic                bad_tail;
    logic                eligible;
    logic                tail_out_of_range;
    logic [31:0]         head_ext;
    logic [31:0]         cmd_addr;
    logic [SQ_IDX_W:0]   head_inc;

`ifdef SQ_TIMEOUT_EN
    logic        err_to_q;
    logic [31:0] watchdog;
    assign err_timeout = err_to_q;
`else
    assign err_timeout = 1'b0;
`endif

    assign head_ext          = 32'(head);
    assign cmd_addr          = sq_base_addr + head_ext * WQE_BYTES;
    assign head_inc          = {1'b0, head} + (SQ_IDX_W+1)'(1);
    assign tail_out_of_range = ({1'b0, sq_tail} >= sq_size);
    assign eligible          = global_enable && (sq_size != '0) && !tail_out_of_range &&
                               (head != sq_tail) && !err_timeout;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            head     <= '0;
            cmd      <= '0;
            wqe_cnt  <= '0;
            spurious <= '0;
            bad_tail <= 1'b0;
`ifdef SQ_TIMEOUT_EN
            err_to_q <= 1'b0;
            watchdog <= '0;
`endif
        end else begin
            if ((sq_size != '0) && tail_out_of_range)
                bad_tail <= 1'b1;
            if (mm2s_rd_xfer_cmplt && (state != WAIT_CMPLT) && (spurious != 8'hFF))
                spurious <= spurious + 8'd1;

            case (state)
                IDLE: begin
                    if (eligible) begin
                        state <= ISSUE;
                        // Address and tag are captured here so later config writes cannot disturb the command.
                        cmd   <= {4'd0, head_ext[3:0], cmd_addr, 1'b0, 1'b1, 6'd0, 1'b1, 23'(WQE_BYTES)};
                    end
                end
                ISSUE: begin
                    if (m_axis_mm2s_cmd_tready) begin
                        state <= WAIT_CMPLT;
`ifdef SQ_TIMEOUT_EN
                        watchdog <= '0;
`endif
                    end
                end
                WAIT_CMPLT: begin
                    if (mm2s_rd_xfer_cmplt) begin
                        state <= ADVANCE;
`ifdef SQ_TIMEOUT_EN
                    end else if (watchdog == 32'(TIMEOUT_CYCLES - 1)) begin
                        err_to_q <= 1'b1;
                        state    <= IDLE;
                    end else begin
                        watchdog <= watchdog + 32'd1;
`endif
                    end
                end
                ADVANCE: begin
                    head    <= (head_inc == sq_size) ? '0 : head_inc[SQ_IDX_W-1:0];
                    wqe_cnt <= wqe_cnt + 32'd1;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign hw_sq_head             = head;
    assign wqe_processed          = wqe_cnt;
    assign busy                   = (state != IDLE);
    assign m_axis_mm2s_cmd_tvalid = (state == ISSUE);
    assign m_axis_mm2s_cmd_tdata  = cmd;

    // Packed to 32 bits with flags in [11:8], head in [23:16], spurious count in [31:24].
    assign debug_status_word = {spurious, 8'(head), 4'd0, bad_tail, err_timeout, global_enable, busy,
                                6'd0, state};

endmodule

// File: tb/tb_sq_fetch_sched.sv
// Scoreboard bench for sq_fetch_sched: expected commands are queued as the tail is moved
// and popped by a monitor on each command handshake.
module tb_sq_fetch_sched;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        global_enable = 1'b0;
    logic [31:0] sq_base_addr = '0;
    logic [4:0]  sq_size = '0;
    logic [3:0]  sq_tail = '0;
    logic [3:0]  hw_sq_head;
    logic [71:0] tdata;
    logic        tvalid;
    logic        tready = 1'b1;
    logic        cmplt = 1'b0;
    logic        busy;
    logic [31:0] wqe_processed;
    logic        err_timeout;
    logic [31:0] dbg;

    int checks = 0;
    int passes = 0;
    int cmd_count = 0;
    int due = 0;
    bit auto_cmplt = 1'b1;
    bit pulse_req = 1'b0;
    logic [71:0] sb[$];

    sq_fetch_sched #(.WQE_BYTES(64), .SQ_IDX_W(4), .TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .rst(rst), .global_enable(global_enable), .sq_base_addr(sq_base_addr),
        .sq_size(sq_size), .sq_tail(sq_tail), .hw_sq_head(hw_sq_head),
        .m_axis_mm2s_cmd_tdata(tdata), .m_axis_mm2s_cmd_tvalid(tvalid),
        .m_axis_mm2s_cmd_tready(tready), .mm2s_rd_xfer_cmplt(cmplt), .busy(busy),
        .wqe_processed(wqe_processed), .err_timeout(err_timeout), .debug_status_word(dbg)
    );

    always #5 clk = ~clk;

    function automatic logic [71:0] exp_cmd(input logic [31:0] base, input int idx);
        logic [31:0] a;
        logic [3:0]  t;
        a = base + 32'(idx) * 32'd64;
        t = 4'(idx);
        return {4'h0, t, a, 1'b0, 1'b1, 6'd0, 1'b1, 23'd64};
    endfunction

    // Negedge values are what the next rising edge samples.
    always @(negedge clk) begin
        cmplt = 1'b0;
        if (rst) due = 0;
        if (pulse_req) begin
            cmplt = 1'b1;
            pulse_req = 1'b0;
        end else if (due == 1) cmplt = 1'b1;
        if (due > 0) due--;
        if (!rst && tvalid && tready) begin
            cmd_count++;
            checks++;
            if (sb.size() == 0)
                $display("FAIL unexpected_cmd: got tdata=%h, required no command", tdata);
            else begin
                logic [71:0] e;
                e = sb.pop_front();
                if (tdata !== e) $display("FAIL cmd_tdata: got %h, required %h", tdata, e);
                else passes++;
            end
            if (auto_cmplt) due = 2;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        sb.delete();
    endtask

    task automatic wait_idle(input logic [3:0] want_head, input string name);
        int n = 0;
        while ((busy || hw_sq_head != want_head) && n < 200) begin
            tick(1);
            n++;
        end
        checks++;
        if (n >= 200) $display("FAIL %s_timeout: head=%0d busy=%0b, required head=%0d idle", name, hw_sq_head, busy, want_head);
        else passes++;
    endtask

    task automatic wait_wait_state(input string name);
        int n = 0;
        while (!(busy && !tvalid) && n < 50) begin
            tick(1);
            n++;
        end
        checks++;
        if (n >= 50) $display("FAIL %s_no_wait: busy=%0b tvalid=%0b, required WAIT_CMPLT", name, busy, tvalid);
        else passes++;
    endtask

    task automatic config_ring();
        sq_base_addr = 32'h1000_0000;
        sq_size = 5'd8;
        global_enable = 1'b1;
        tready = 1'b1;
        auto_cmplt = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({hw_sq_head, tvalid, busy, err_timeout} !== 7'd0 || tdata !== 72'd0 || wqe_processed !== 32'd0 || dbg !== 32'd0)
            $display("FAIL reset_state: head=%0d tvalid=%0b tdata=%h wqe=%0d dbg=%h, required all zero", hw_sq_head, tvalid, tdata, wqe_processed, dbg);
        else passes++;
    endtask

    task automatic test_basic();
        config_ring();
        tick(1);
        sb.push_back(exp_cmd(32'h1000_0000, 0));
        sq_tail = 4'd1;
        tick(1);
        checks++;
        if (tvalid !== 1'b1) $display("FAIL issue_latency: tvalid=%0b, required 1", tvalid);
        else passes++;
        wait_idle(4'd1, "basic");
        checks++;
        if (wqe_processed !== 32'd1 || sb.size() != 0) $display("FAIL basic_count: wqe=%0d pending=%0d, required 1/0", wqe_processed, sb.size());
        else passes++;
    endtask

    task automatic test_wrap();
        for (int i = 1; i < 7; i++) sb.push_back(exp_cmd(32'h1000_0000, i));
        sq_tail = 4'd7;
        wait_idle(4'd7, "fill");
        sb.push_back(exp_cmd(32'h1000_0000, 7));
        sq_tail = 4'd0;
        wait_idle(4'd0, "wrap");
        checks++;
        if (wqe_processed !== 32'd8 || sb.size() != 0 || dbg[23:16] !== 8'd0)
            $display("FAIL wrap_state: wqe=%0d pending=%0d dbg=%h, required 8/0 head 0", wqe_processed, sb.size(), dbg);
        else passes++;
    endtask

    task automatic test_back_pressure();
        int c0;
        do_reset();
        config_ring();
        tready = 1'b0;
        c0 = cmd_count;
        for (int i = 0; i < 3; i++) sb.push_back(exp_cmd(32'h1000_0000, i));
        sq_tail = 4'd3;
        tick(1);
        for (int i = 0; i < 5; i++) begin
            if (i == 2) sq_base_addr = 32'hDEAD_0000;
            checks++;
            if (tvalid !== 1'b1 || tdata !== exp_cmd(32'h1000_0000, 0))
                $display("FAIL hold_cycle%0d: tvalid=%0b tdata=%h, required 1 %h", i, tvalid, tdata, exp_cmd(32'h1000_0000, 0));
            else passes++;
            tick(1);
        end
        sq_base_addr = 32'h1000_0000;
        tready = 1'b1;
        wait_idle(4'd3, "bp");
        checks++;
        if (cmd_count - c0 != 3 || wqe_processed !== 32'd3) $display("FAIL bp_count: cmds=%0d wqe=%0d, required 3/3", cmd_count - c0, wqe_processed);
        else passes++;
    endtask

    task automatic test_disable();
        int c0;
        auto_cmplt = 1'b0;
        c0 = cmd_count;
        sb.push_back(exp_cmd(32'h1000_0000, 3));
        sq_tail = 4'd6;
        wait_wait_state("dis");
        global_enable = 1'b0;
        tick(3);
        checks++;
        if (busy !== 1'b1 || hw_sq_head !== 4'd3) $display("FAIL dis_hold: busy=%0b head=%0d, required 1/3", busy, hw_sq_head);
        else passes++;
        pulse_req = 1'b1;
        tick(12);
        checks++;
        if (hw_sq_head !== 4'd4 || busy !== 1'b0 || cmd_count - c0 != 1 || wqe_processed !== 32'd4)
            $display("FAIL dis_stop: head=%0d busy=%0b cmds=%0d wqe=%0d, required 4/0/1/4", hw_sq_head, busy, cmd_count - c0, wqe_processed);
        else passes++;
        auto_cmplt = 1'b1;
    endtask

    task automatic test_bad_tail();
        int c0;
        do_reset();
        config_ring();
        c0 = cmd_count;
        sq_tail = 4'd9;
        tick(6);
        checks++;
        if (cmd_count != c0 || busy !== 1'b0 || dbg[11] !== 1'b1) $display("FAIL bad_tail: cmds=%0d busy=%0b dbg=%h, required 0/0 bit11 set", cmd_count - c0, busy, dbg);
        else passes++;
        pulse_req = 1'b1;
        tick(2);
        checks++;
        if (dbg[31:24] !== 8'd1 || hw_sq_head !== 4'd0) $display("FAIL spurious: dbg=%h head=%0d, required spurious 1 head 0", dbg, hw_sq_head);
        else passes++;
    endtask

    task automatic test_reset_mid();
        do_reset();
        config_ring();
        tready = 1'b0;
        sq_tail = 4'd0;
        tick(1);
        sb.push_back(exp_cmd(32'h1000_0000, 0));
        sq_tail = 4'd2;
        tick(3);
        rst = 1'b1;
        tick(1);
        checks++;
        if (tvalid !== 1'b0 || tdata !== 72'd0 || busy !== 1'b0 || dbg[7:0] !== 8'd0)
            $display("FAIL mid_reset: tvalid=%0b tdata=%h busy=%0b, required all zero", tvalid, tdata, busy);
        else passes++;
        global_enable = 1'b0;
        tready = 1'b1;
        tick(1);
        rst = 1'b0;
        sb.delete();
    endtask

`ifdef SQ_TIMEOUT_EN
    task automatic test_timeout();
        int c0;
        do_reset();
        config_ring();
        auto_cmplt = 1'b0;
        sb.push_back(exp_cmd(32'h1000_0000, 0));
        sq_tail = 4'd1;
        wait_wait_state("to");
        c0 = cmd_count;
        tick(15);
        checks++;
        if (err_timeout !== 1'b0 || busy !== 1'b1) $display("FAIL to_early: err=%0b busy=%0b, required 0/1", err_timeout, busy);
        else passes++;
        tick(1);
        checks++;
        if (err_timeout !== 1'b1 || busy !== 1'b0 || hw_sq_head !== 4'd0 || dbg[10] !== 1'b1)
            $display("FAIL to_fire: err=%0b busy=%0b head=%0d dbg=%h, required 1/0/0", err_timeout, busy, hw_sq_head, dbg);
        else passes++;
        tick(10);
        checks++;
        if (cmd_count != c0 || busy !== 1'b0) $display("FAIL to_reissue: cmds=%0d busy=%0b, required 0/0", cmd_count - c0, busy);
        else passes++;
        global_enable = 1'b0;
        do_reset();
        checks++;
        if (err_timeout !== 1'b0 || dbg !== 32'd0) $display("FAIL to_clear: err=%0b dbg=%h, required 0", err_timeout, dbg);
        else passes++;
        auto_cmplt = 1'b1;
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_wrap();
        test_back_pressure();
        test_disable();
        test_bad_tail();
        test_reset_mid();
`ifdef SQ_TIMEOUT_EN
        test_timeout();
`endif
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
